// File: rtl/keypad_scan_entry_if.sv
// Committed-value stream between the keypad entry block and its consumer.
//   out_data  : committed value (VAL_W bits), valid while out_valid is high
//   out_valid : committed value available
//   out_ready : consumer accepts out_data (ignored while out_valid is low)
// master = producer (keypad_scan_entry), slave = consumer.
interface keypad_scan_entry_if #(
  parameter int unsigned VAL_W = 16
) ();
  logic [VAL_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/keypad_scan_entry.sv
// Matrix keypad scanner with debounce and a decimal value-entry state machine.
//   clk, rst     : clock, asynchronous active-high reset
//   row          : keypad rows, active-low, asynchronous to clk
//   col          : one-hot active-high column drive
//   key_code     : code of the last accepted key (from KEYMAP)
//   key_valid    : one-cycle pulse per accepted press
//   key_held     : high while a debounced key is down
//   entry_active : high while the entry FSM is in ENTRY
//   cur_val, ovf : live accumulator and sticky overflow flag
//   out_if       : committed value stream (out_data/out_valid/out_ready)
module keypad_scan_entry #(
  parameter int unsigned            ROWS     = 4,
  parameter int unsigned            COLS     = 4,
  parameter int unsigned            SCAN_DIV = 524288,
  parameter int unsigned            DEBOUNCE = 3,
  parameter int unsigned            VAL_W    = 16,
  parameter logic [ROWS*COLS*4-1:0] KEYMAP   = 64'hDF0E_C987_B654_A321
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ROWS-1:0]     row,
  output logic [COLS-1:0]     col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                entry_active,
  output logic [VAL_W-1:0]    cur_val,
  output logic                ovf,
  keypad_scan_entry_if.master out_if
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned NKEY   = ROWS * COLS;
  localparam int unsigned IDX_W  = $clog2(NKEY);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
  localparam int unsigned PROD_W = VAL_W + 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [ROWS-1:0]   row_meta, row_sync;
  logic [SCAN_W-1:0] scan_cnt;
  logic              dwell_end, col_onehot, frame_close;
  logic [COL_W-1:0]  col_idx;
  logic [ROW_W-1:0]  lo_row;
  logic [1:0]        lo_cnt, frm_hits, base_hits, hits_nx;
  logic [2:0]        hits_sum;
  logic [IDX_W-1:0]  frm_idx, base_idx, idx_nx, samp_idx;
  logic              fr_single;
  logic              cand_single;
  logic [IDX_W-1:0]  cand_idx, stb_idx;
  logic [DB_W-1:0]   db_cnt, cnt_nx;
  logic              same_cls, diff_stb, accept;

  logic [1:0]        state, state_nx;
  logic [VAL_W-1:0]  cur_nx, out_data_q, odata_nx;
  logic              ovf_nx, out_valid_q, ovalid_nx;
  logic [PROD_W-1:0] prod;

  // Two-flop synchronizer for the asynchronous row inputs (idle high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign dwell_end  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign col_onehot = $onehot(col);

  // Column dwell counter and rotating one-hot drive; stray patterns recover to bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      col      <= COLS'(1);
    end else if (dwell_end) begin
      scan_cnt <= '0;
      col      <= col_onehot ? {col[COLS-2:0], col[COLS-1]} : COLS'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Classify the current sample and merge it into the running frame (hits saturate at 2)
  always_comb begin
    col_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col[c]) col_idx = COL_W'(c);
    end
    lo_cnt = '0;
    lo_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_sync[r]) begin
        if (lo_cnt != 2'd2) lo_cnt = lo_cnt + 2'd1;
        lo_row = ROW_W'(r);
      end
    end
    samp_idx  = IDX_W'(32'(lo_row) * COLS + 32'(col_idx));
    base_hits = col[0] ? 2'd0 : frm_hits;
    base_idx  = col[0] ? '0 : frm_idx;
    hits_sum  = 3'(base_hits) + 3'(lo_cnt);
    hits_nx   = (hits_sum >= 3'd2) ? 2'd2 : 2'(hits_sum);
    idx_nx    = (base_hits == 2'd0 && lo_cnt == 2'd1) ? samp_idx : base_idx;
  end

  // Frame result; MULTI collapses to NONE, NONE carries index 0
  assign frame_close = dwell_end && col_onehot && col[COLS-1];
  assign fr_single   = (hits_nx == 2'd1);

  always_comb begin
    same_cls = (fr_single == cand_single) && (!fr_single || idx_nx == cand_idx);
    if (!same_cls)                         cnt_nx = DB_W'(1);
    else if (db_cnt == DB_W'(DEBOUNCE))    cnt_nx = db_cnt;
    else                                   cnt_nx = db_cnt + DB_W'(1);
    accept   = (cnt_nx == DB_W'(DEBOUNCE));
    diff_stb = (fr_single != key_held) || (fr_single && idx_nx != stb_idx);
  end

  // Frame accumulator, debounce candidate and accepted key state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_hits    <= '0;
      frm_idx     <= '0;
      cand_single <= 1'b0;
      cand_idx    <= '0;
      db_cnt      <= '0;
      key_held    <= 1'b0;
      stb_idx     <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (dwell_end) begin
        frm_hits <= hits_nx;
        frm_idx  <= idx_nx;
      end
      if (frame_close) begin
        cand_single <= fr_single;
        cand_idx    <= fr_single ? idx_nx : '0;
        db_cnt      <= cnt_nx;
        if (accept && diff_stb) begin
          key_held <= fr_single;
          stb_idx  <= fr_single ? idx_nx : '0;
          if (fr_single) begin
            key_valid <= 1'b1;
            key_code  <= KEYMAP[{idx_nx, 2'b00} +: 4];
          end
        end
      end
    end
  end

  // Entry FSM next state and register inputs
  always_comb begin
    state_nx  = state;
    cur_nx    = cur_val;
    ovf_nx    = ovf;
    odata_nx  = out_data_q;
    ovalid_nx = out_valid_q;
    prod      = PROD_W'(cur_val) * PROD_W'(10) + PROD_W'(key_code);
    case (state)
      S_IDLE: begin
        if (key_valid && key_code == 4'hE) begin
          cur_nx   = '0;
          ovf_nx   = 1'b0;
          state_nx = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (prod[PROD_W-1:VAL_W] != '0) ovf_nx = 1'b1;
            else                            cur_nx = prod[VAL_W-1:0];
          end else begin
            case (key_code)
              4'hA: cur_nx = cur_val / VAL_W'(10);
              4'hD, 4'hE: begin
                cur_nx = '0;
                ovf_nx = 1'b0;
              end
              4'hF: begin
                odata_nx  = cur_val;
                ovalid_nx = 1'b1;
                state_nx  = S_HOLD;
              end
              default: ;
            endcase
          end
        end
      end
      S_HOLD: begin
        // Keys are dropped here, including one coinciding with out_ready
        if (out_if.out_ready) begin
          ovalid_nx = 1'b0;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Entry FSM state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cur_val      <= '0;
      ovf          <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      entry_active <= 1'b0;
    end else begin
      state        <= state_nx;
      cur_val      <= cur_nx;
      ovf          <= ovf_nx;
      out_data_q   <= odata_nx;
      out_valid_q  <= ovalid_nx;
      entry_active <= (state_nx == S_ENTRY);
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_keypad_scan_entry.sv
`timescale 1ns/1ps
module tb_keypad_scan_entry;

  localparam int unsigned SD     = 4;
  localparam int unsigned DB     = 2;
  localparam int unsigned VW     = 8;
  localparam int unsigned FRAME  = 4 * SD;
  localparam int unsigned FRAME2 = 3 * SD;
  localparam longint      MAXV   = (64'd1 << VW) - 1;
  localparam logic [23:0] KM2    = 24'h864B25;

  logic          clk, rst;
  logic [3:0]    row1, col1, key_code1;
  logic          key_valid1, key_held1, entry_active1, ovf1;
  logic [VW-1:0] cur_val1;
  logic [1:0]    row2;
  logic [2:0]    col2;
  logic [3:0]    key_code2;
  logic          key_valid2, key_held2, entry_active2, ovf2;
  logic [VW-1:0] cur_val2;
  logic [15:0]   prs1;
  logic [5:0]    prs2;

  keypad_scan_entry_if #(.VAL_W(VW)) if1 ();
  keypad_scan_entry_if #(.VAL_W(VW)) if2 ();

  keypad_scan_entry #(.ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE(DB), .VAL_W(VW)) dut1 (
    .clk(clk), .rst(rst), .row(row1), .col(col1), .key_code(key_code1),
    .key_valid(key_valid1), .key_held(key_held1), .entry_active(entry_active1),
    .cur_val(cur_val1), .ovf(ovf1), .out_if(if1)
  );

  keypad_scan_entry #(.ROWS(2), .COLS(3), .SCAN_DIV(SD), .DEBOUNCE(DB), .VAL_W(VW),
                      .KEYMAP(KM2)) dut2 (
    .clk(clk), .rst(rst), .row(row2), .col(col2), .key_code(key_code2),
    .key_valid(key_valid2), .key_held(key_held2), .entry_active(entry_active2),
    .cur_val(cur_val2), .ovf(ovf2), .out_if(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    for (int r = 0; r < 4; r++) row1[r] = ~|(prs1[r*4 +: 4] & col1);
    for (int r = 0; r < 2; r++) row2[r] = ~|(prs2[r*3 +: 3] & col2);
  end

  int legend1 [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int legend2 [6]  = '{5, 2, 11, 4, 6, 8};

  int checks = 0;
  int errors = 0;
  int kv1 = 0;
  int kv2 = 0;

  // Reference model of the entry behaviour
  int     m_state;  // 0 idle, 1 entry, 2 hold
  longint m_cur, m_ovf, m_out, m_ovalid, m_code, m_kv;

  always @(negedge clk) begin
    if (key_valid1) kv1++;
    if (key_valid2) kv2++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int idx_of(input int code);
    for (int i = 0; i < 16; i++) if (legend1[i] == code) return i;
    return 0;
  endfunction

  task automatic model_key(input int code);
    longint t;
    m_kv++;
    m_code = code;
    case (m_state)
      0: if (code == 14) begin m_cur = 0; m_ovf = 0; m_state = 1; end
      1: begin
        if (code <= 9) begin
          t = m_cur * 10 + code;
          if (t > MAXV) m_ovf = 1; else m_cur = t;
        end else if (code == 10) m_cur = m_cur / 10;
        else if (code == 13 || code == 14) begin m_cur = 0; m_ovf = 0; end
        else if (code == 15) begin m_out = m_cur; m_ovalid = 1; m_state = 2; end
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_ovf = 0; m_out = 0; m_ovalid = 0; m_code = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".cur_val"}, 64'(cur_val1), 64'(m_cur));
    check({tag, ".ovf"}, 64'(ovf1), 64'(m_ovf));
    check({tag, ".entry"}, 64'(entry_active1), 64'(m_state == 1));
    check({tag, ".out_valid"}, 64'(if1.out_valid), 64'(m_ovalid));
    check({tag, ".out_data"}, 64'(if1.out_data), 64'(m_out));
    check({tag, ".kv_count"}, 64'(kv1), 64'(m_kv));
    check({tag, ".key_code"}, 64'(key_code1), 64'(m_code));
  endtask

  // Press one key cleanly; optionally raise out_ready in the key_valid cycle
  task automatic press1(input int code, input bit with_ready);
    bit done;
    bool_dummy: begin end
    done = 0;
    prs1 = '0;
    prs1[idx_of(code)] = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (with_ready && !done && key_valid1) begin
        if1.out_ready = 1'b1;
        done = 1;
        @(negedge clk);
        if1.out_ready = 1'b0;
      end
    end
    prs1 = '0;
    tick(4 * FRAME);
    if (with_ready) begin
      check("ready_with_key.seen", 64'(done), 64'd1);
      m_kv++;
      m_code = code;
      if (m_state == 2) begin m_state = 0; m_ovalid = 0; end
    end else begin
      model_key(code);
    end
  endtask

  task automatic pulse_ready();
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.out_ready = 1'b0;
    if (m_state == 2) begin m_state = 0; m_ovalid = 0; end
    tick(2);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".col"}, 64'(col1), 64'd1);
    check({tag, ".col2"}, 64'(col2), 64'd1);
    check({tag, ".key_code"}, 64'(key_code1), 64'd0);
    check({tag, ".key_valid"}, 64'(key_valid1), 64'd0);
    check({tag, ".key_held"}, 64'(key_held1), 64'd0);
    check({tag, ".entry"}, 64'(entry_active1), 64'd0);
    check({tag, ".cur_val"}, 64'(cur_val1), 64'd0);
    check({tag, ".ovf"}, 64'(ovf1), 64'd0);
    check({tag, ".out_data"}, 64'(if1.out_data), 64'd0);
    check({tag, ".out_valid"}, 64'(if1.out_valid), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    prs1 = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values(tag);
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(4 * FRAME);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lows, kv_before, code, r, tmp, j;
    bit wr;
    int ord [6];

    rst = 1'b0; prs1 = '0; prs2 = '0;
    if1.out_ready = 1'b0; if2.out_ready = 1'b0;
    model_reset();
    m_kv = 0;
    #1 rst = 1'b1;
    #2 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Column rotation right after reset release: 4 cycles per dwell
    @(negedge clk);
    check("col2.t1", 64'(col2), 64'b001);
    tick(4);
    check("col2.t5", 64'(col2), 64'b010);
    check("col1.t5", 64'(col1), 64'b0010);
    tick(4);
    check("col2.t9", 64'(col2), 64'b100);
    tick(4);
    check("col2.t13", 64'(col2), 64'b001);
    check("col1.t13", 64'(col1), 64'b1000);
    tick(4 * FRAME);
    check_state("idle");

    // Enter 123 and commit it
    press1(14, 0); check_state("e123.star");
    press1(1, 0);  check_state("e123.1");
    press1(2, 0);  check_state("e123.2");
    press1(3, 0);  check_state("e123.3");
    check("e123.value", 64'(cur_val1), 64'd123);
    press1(15, 0); check_state("e123.hash");
    tick(5 * FRAME);
    check("e123.out_data_stable", 64'(if1.out_data), 64'd123);
    check("e123.out_valid_stable", 64'(if1.out_valid), 64'd1);
    pulse_ready(); check_state("e123.ready");

    // Overflow, backspace and clear
    press1(14, 0); press1(2, 0); press1(5, 0); press1(6, 0);
    check_state("ovf.256");
    check("ovf.flag", 64'(ovf1), 64'd1);
    press1(10, 0); check_state("ovf.A");
    press1(13, 0); check_state("ovf.D");
    press1(15, 0); pulse_ready(); check_state("ovf.commit");

    // Long hold: one pulse, key_held stays high
    kv_before = kv1;
    prs1 = '0; prs1[idx_of(5)] = 1'b1;
    tick(3 * FRAME);
    check("hold.held_early", 64'(key_held1), 64'd1);
    lows = 0;
    for (int i = 0; i < 7 * FRAME; i++) begin
      @(negedge clk);
      if (!key_held1) lows++;
    end
    check("hold.held_lows", 64'(lows), 64'd0);
    prs1 = '0;
    tick(4 * FRAME);
    check("hold.pulses", 64'(kv1 - kv_before), 64'd1);
    check("hold.released", 64'(key_held1), 64'd0);
    model_key(5);
    check_state("hold");

    // Bounce: visible in one frame only
    kv_before = kv1;
    prs1 = '0; prs1[idx_of(9)] = 1'b1;
    tick(FRAME);
    prs1 = '0;
    tick(4 * FRAME);
    check("bounce.pulses", 64'(kv1 - kv_before), 64'd0);

    // Two keys together
    prs1 = '0; prs1[idx_of(1)] = 1'b1; prs1[idx_of(2)] = 1'b1;
    tick(5 * FRAME);
    check("multi.held", 64'(key_held1), 64'd0);
    prs1 = '0;
    tick(4 * FRAME);
    check("multi.pulses", 64'(kv1 - kv_before), 64'd0);

    // HOLD ignores keys; ready coinciding with a key drops the key
    press1(14, 0); press1(4, 0); press1(15, 0);
    press1(7, 0); check_state("holdkey.7");
    check("holdkey.out_data", 64'(if1.out_data), 64'd4);
    press1(14, 1); check_state("holdkey.ready_same");
    check("holdkey.idle", 64'(entry_active1), 64'd0);

    // Reset mid-entry, then mid-HOLD
    press1(14, 0); press1(8, 0);
    do_reset("rst_entry");
    check_state("rst_entry.after");
    press1(14, 0); press1(9, 0); press1(15, 0);
    do_reset("rst_hold");
    tick(4 * FRAME);
    check_state("rst_hold.after");

    // Randomized key sequences against the model
    for (int it = 0; it < 45; it++) begin
      wr = 0;
      if (m_state == 0) begin
        code = ($urandom_range(0, 1) != 0) ? 14 : int'($urandom_range(0, 15));
      end else if (m_state == 1) begin
        r = $urandom_range(0, 19);
        code = (r < 12) ? (r % 10) : ((r == 19) ? 15 : int'($urandom_range(10, 15)));
      end else begin
        code = $urandom_range(0, 15);
        wr = ($urandom_range(0, 2) == 0);
      end
      press1(code, wr);
      check_state($sformatf("rand%0d", it));
      if ($urandom_range(0, 3) == 0) begin
        pulse_ready();
        check_state($sformatf("rand%0d.rdy", it));
      end
    end

    // Small 2x3 keypad with a custom map
    for (int i = 0; i < 6; i++) ord[i] = i;
    for (int i = 5; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
    end
    for (int i = 0; i < 6; i++) begin
      kv_before = kv2;
      prs2 = '0; prs2[ord[i]] = 1'b1;
      tick(4 * FRAME2);
      check($sformatf("small%0d.held", ord[i]), 64'(key_held2), 64'd1);
      prs2 = '0;
      tick(4 * FRAME2);
      check($sformatf("small%0d.pulses", ord[i]), 64'(kv2 - kv_before), 64'd1);
      check($sformatf("small%0d.code", ord[i]), 64'(key_code2), 64'(legend2[ord[i]]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_entry.md
KEYPAD_SCAN_ENTRY -- requirements
Module: keypad_scan_entry

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad row inputs (2..8).
REQ-002 SHALL have parameter COLS, default 4, number of keypad column drives (2..8).
REQ-003 SHALL have parameter SCAN_DIV, default 524288, clk cycles per column dwell (>=4).
REQ-004 SHALL have parameter DEBOUNCE, default 3, consecutive identical scan frames before a key state is accepted (>=1).
REQ-005 SHALL have parameter VAL_W, default 16, width of the entered unsigned value (4..32).
REQ-006 SHALL have parameter KEYMAP, ROWS*COLS*4 bits; nibble r*COLS+c is the code of key (row r, col c). The default is the 4x4 legend 1,2,3,A / 4,5,6,B / 7,8,9,C / *(E),0,#(F),D with row 0 first.
REQ-007 SHALL have port clk, input, 1, system clock.
REQ-008 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-009 SHALL have port row, input, ROWS, keypad rows, active-low, asynchronous to clk.
REQ-010 SHALL have port col, output, COLS, one-hot active-high column drive.
REQ-011 SHALL have port key_code, output, 4, code of the last accepted key.
REQ-012 SHALL have port key_valid, output, 1, one-cycle pulse per accepted press.
REQ-013 SHALL have port key_held, output, 1, high while a debounced key is down.
REQ-014 SHALL have port entry_active, output, 1, high in state ENTRY.
REQ-015 SHALL have port cur_val, output, VAL_W, live accumulator for display.
REQ-016 SHALL have port ovf, output, 1, sticky overflow flag for the current entry.
REQ-017 SHALL have port out_data, output, VAL_W, committed value.
REQ-018 SHALL have port out_valid, output, 1, committed value available.
REQ-019 SHALL have port out_ready, input, 1, consumer accepts out_data.

Function
REQ-020 SHALL pass row through a 2-flop synchronizer before use.
REQ-021 SHALL hold each col pattern for SCAN_DIV clk cycles, then shift left one bit, wrapping from bit COLS-1 to bit 0; any non-one-hot col value SHALL be replaced by bit 0 at the next advance.
REQ-022 SHALL sample the synchronized row in the last cycle of each dwell; a frame is COLS consecutive dwells starting at col bit 0.
REQ-023 SHALL classify each frame as: NONE (no low row bit), SINGLE(index r*COLS+c) (exactly one low bit in the whole frame), or MULTI (two or more low bits, treated as NONE).
REQ-024 SHALL accept a new debounced state only after DEBOUNCE consecutive frames with the identical classification.
REQ-025 SHALL pulse key_valid for one clk cycle and load key_code from KEYMAP on a transition NONE->SINGLE, one cycle after the closing sample; a held key SHALL NOT repeat, and a SINGLE->different SINGLE transition SHALL produce a new pulse.
REQ-026 SHALL set key_held while the debounced state is SINGLE.
REQ-027 SHALL implement entry FSM states IDLE, ENTRY, HOLD, with each key acting on the cycle after key_valid.
REQ-028 In IDLE, code E SHALL clear cur_val and ovf and go to ENTRY; all other codes SHALL be ignored.
REQ-029 In ENTRY, digit d (0..9) SHALL set cur_val = cur_val*10+d, computed at VAL_W+4 bits; if the result exceeds 2^VAL_W-1, cur_val SHALL be unchanged and ovf SHALL be set.
REQ-030 In ENTRY, code A SHALL set cur_val = cur_val/10 (truncating), D SHALL clear cur_val and ovf, E SHALL restart (clear and stay in ENTRY), B and C SHALL be ignored.
REQ-031 In ENTRY, code F SHALL load out_data=cur_val, assert out_valid, and go to HOLD.
REQ-032 In HOLD, all keys SHALL be ignored; out_valid and out_data SHALL stay stable until a cycle with out_ready=1, after which out_valid SHALL be 0 and state SHALL be IDLE.
REQ-033 A key action and an out_ready in the same cycle in HOLD SHALL complete the handshake, and the key SHALL be dropped.
REQ-034 out_ready SHALL be ignored when out_valid=0.

Reset
REQ-035 rst SHALL immediately set col=1, scan and debounce counters to 0, debounced state NONE, key_code=0, key_valid=0, key_held=0, FSM=IDLE, cur_val=0, ovf=0, out_data=0, out_valid=0.
REQ-036 rst asserted mid-entry or in HOLD SHALL discard the pending value with no out_valid pulse after release.

Verification (SCAN_DIV=4, DEBOUNCE=2, VAL_W=8, default KEYMAP)
REQ-037 Press *,1,2,3,# then out_ready=1 -> cur_val 1,12,123; out_data=123 with out_valid held until the ready cycle, then IDLE.
REQ-038 In ENTRY, press 2,5,6 -> cur_val=25, ovf=1 (256>255); then A -> cur_val=2; then D -> cur_val=0, ovf=0.
REQ-039 Hold key 5 for 10 frames -> exactly one key_valid, key_code=5, key_held high throughout.
REQ-040 Key bounces (pressed in frame 1 only, released in frame 2) -> no key_valid; keys 1 and 2 pressed together -> no key_valid (MULTI).
REQ-041 In HOLD with out_ready=0, press 7 -> out_data is unchanged and no state change; assert rst during ENTRY -> all outputs return to reset values.
REQ-042 Run ROWS=2, COLS=3 -> col sequence 001,010,100,001 every 4 cycles, and key_code follows the supplied KEYMAP.
